// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: word size and buffer defaults shared
// between the UART receiver and its receive FIFO.
package uart_rx_fifo_pkg;

  localparam int UART_DW    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_AFULL = 12;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver write port, host read port
// and status bundle of the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();

  logic [DW-1:0] din;
  logic          we;
  logic          dir;
  logic          host_rd;
  logic [DW-1:0] host_dout;
  logic          host_dor;
  logic          empty;
  logic          afull;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    output din, we, host_rd, ovf_clr,
    input  dir, host_dout, host_dor,
    input  empty, afull, count, overflow
  );

  modport slave (
    input  din, we, host_rd, ovf_clr,
    output dir, host_dout, host_dor,
    output empty, afull, count, overflow
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: negedge-clocked FWFT receive buffer with
// strobe-based host pops and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DW        = UART_DW,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AW        = FIFO_AW,
  parameter int AFULL_LVL = FIFO_AFULL
) (
  input logic          clk,
  input logic          reset_b,
  uart_rx_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rd_q;
  logic          armed;
  logic          overflow;

  logic full;
  logic is_empty;
  logic wr_ok;
  logic lead;
  logic trail;
  logic pop;

  assign full     = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign wr_ok    = bus.we & ~full;
  assign lead     = bus.host_rd & ~rd_q;
  assign trail    = rd_q & ~bus.host_rd;
  // Pop only on the trailing edge of a strobe that
  // found data at its leading edge.
  assign pop      = trail & armed & ~is_empty;

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_q     <= 1'b0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_q <= bus.host_rd;
      if (lead) begin
        armed <= ~is_empty;
      end else if (trail) begin
        armed <= 1'b0;
      end
      if (wr_ok) begin
        mem[wr_ptr] <= bus.din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (bus.we && full) begin
        overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.host_dout = mem[rd_ptr];
  assign bus.host_dor  = ~is_empty;
  assign bus.empty     = is_empty;
  assign bus.dir       = ~full;
  assign bus.afull     = (count >= AFULL_CNT);
  assign bus.count     = count;
  assign bus.overflow  = overflow;

endmodule
